// File: rtl/chan_activity_detect.sv
// Receive-side channel activity detector: windowed mean |I|+|Q| with
// a hysteretic on/off decision that drives the registered mode flag.
module chan_activity_detect #(
    parameter int WIN_LOG2    = 6,
    parameter int ON_WINDOWS  = 2,
    parameter int OFF_WINDOWS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_bus_1,
    input  logic [15:0] in_bus_2,
    input  logic [16:0] thr_on,
    input  logic [16:0] thr_off,
    output logic        mode,
    output logic [16:0] energy,
    output logic        energy_valid
);

    localparam int AW   = 17 + WIN_LOG2;
    localparam int WMAX = (ON_WINDOWS > OFF_WINDOWS) ? ON_WINDOWS : OFF_WINDOWS;
    localparam int WW   = (WMAX < 2) ? 1 : $clog2(WMAX + 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_ARM,
        S_ON,
        S_REL
    } state_t;

    logic [16:0]         abs_i, abs_q, mag;
    logic [AW-1:0]       acc_q, acc_d, acc_sum;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [16:0]         energy_q, energy_d;
    logic                ev_q, ev_d;
    state_t              state_q, state_d;
    logic [WW-1:0]       wcnt_q, wcnt_d, wcnt_inc;
    logic                mode_q, mode_d;
    logic                hit_on, hit_off;

    // Negation at 17 bits so that -32768 maps to +32768 without saturating
    assign abs_i   = in_bus_1[15] ? (17'd0 - {1'b1, in_bus_1}) : {1'b0, in_bus_1};
    assign abs_q   = in_bus_2[15] ? (17'd0 - {1'b1, in_bus_2}) : {1'b0, in_bus_2};
    assign mag     = abs_i + abs_q;
    assign acc_sum = acc_q + AW'(mag);

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        energy_d = energy_q;
        ev_d     = 1'b0;
        if (in_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                energy_d = acc_sum[WIN_LOG2 +: 17];
                ev_d     = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            energy_q <= '0;
            ev_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            energy_q <= energy_d;
            ev_q     <= ev_d;
        end
    end

    assign hit_on   = energy_q >= thr_on;
    assign hit_off  = energy_q < thr_off;
    assign wcnt_inc = wcnt_q + WW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            wcnt_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            mode_q  <= mode_d;
        end
    end

    // wcnt is zero in the settled states, so OFF/ON share the arming paths
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (ev_q) begin
            unique case (state_q)
                S_OFF, S_ARM: begin
                    if (hit_on) begin
                        if (wcnt_inc >= WW'(ON_WINDOWS)) begin
                            state_d = S_ON;
                            wcnt_d  = '0;
                        end else begin
                            state_d = S_ARM;
                            wcnt_d  = wcnt_inc;
                        end
                    end else begin
                        state_d = S_OFF;
                        wcnt_d  = '0;
                    end
                end
                S_ON, S_REL: begin
                    if (hit_off) begin
                        if (wcnt_inc >= WW'(OFF_WINDOWS)) begin
                            state_d = S_OFF;
                            wcnt_d  = '0;
                        end else begin
                            state_d = S_REL;
                            wcnt_d  = wcnt_inc;
                        end
                    end else begin
                        state_d = S_ON;
                        wcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        mode_d = (state_d == S_ON) || (state_d == S_REL);
    end

    assign mode         = mode_q;
    assign energy       = energy_q;
    assign energy_valid = ev_q;

endmodule

// File: tb/tb_chan_activity_detect.sv
// Bench for chan_activity_detect: directed window table, corner sequences,
// and a randomized run compared against a window/streak reference model.
module tb_chan_activity_detect;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] bi = '0;
    logic signed [15:0] bq = '0;
    logic [16:0]        thr_on = 17'd1200;
    logic [16:0]        thr_off = 17'd800;
    logic               mode;
    logic [16:0]        energy;
    logic               energy_valid;

    int checks = 0;
    int errors = 0;
    bit mdl_en = 1'b0;

    chan_activity_detect dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_bus_1     (bi),
        .in_bus_2     (bq),
        .thr_on       (thr_on),
        .thr_off      (thr_off),
        .mode         (mode),
        .energy       (energy),
        .energy_valid (energy_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int absv(input logic signed [15:0] v);
        return (v < 0) ? -int'(v) : int'(v);
    endfunction

    // Reference: sum 64 magnitudes, mean = sum/64; mode flips after a
    // streak of 2 loud windows (when off) or 3 quiet windows (when on).
    int m_sum, m_n, m_energy, m_streak;
    bit m_ev, m_mode;

    always @(posedge clk) begin
        if (rst) begin
            m_sum = 0; m_n = 0; m_energy = 0;
            m_streak = 0; m_ev = 0; m_mode = 0;
        end else begin
            if (m_ev) begin
                if (!m_mode) begin
                    m_streak = (m_energy >= int'(thr_on)) ? m_streak + 1 : 0;
                    if (m_streak == 2) begin m_mode = 1; m_streak = 0; end
                end else begin
                    m_streak = (m_energy < int'(thr_off)) ? m_streak + 1 : 0;
                    if (m_streak == 3) begin m_mode = 0; m_streak = 0; end
                end
            end
            m_ev = 0;
            if (in_valid) begin
                m_sum += absv(bi) + absv(bq);
                m_n++;
                if (m_n == 64) begin
                    m_energy = m_sum / 64;
                    m_ev = 1; m_sum = 0; m_n = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_en) begin
            chk("mdl_ev", int'(energy_valid), int'(m_ev));
            chk("mdl_energy", int'(energy), m_energy);
            chk("mdl_mode", int'(mode), int'(m_mode));
        end
    end

    typedef struct {
        int i;
        int q;
        int exp_energy;
        int exp_mode;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input bit v, input int i, input int q);
        in_valid = v;
        bi = 16'(i);
        bq = 16'(q);
    endtask

    task automatic samples(input int n, input int i, input int q);
        for (int k = 0; k < n; k++) begin
            drive(1, i, q);
            @(negedge clk);
        end
        drive(0, 0, 0);
    endtask

    initial begin
        int first_ev;

        vecs[0]  = '{1000, -500, 1500, 0};
        vecs[1]  = '{1000, -500, 1500, 1};
        vecs[2]  = '{600, 400, 1000, 1};
        vecs[3]  = '{-250, 250, 500, 1};
        vecs[4]  = '{-250, 250, 500, 1};
        vecs[5]  = '{1000, -500, 1500, 1};
        vecs[6]  = '{-250, 250, 500, 1};
        vecs[7]  = '{-250, 250, 500, 1};
        vecs[8]  = '{-250, 250, 500, 0};
        vecs[9]  = '{-32768, -32768, 65536, 0};
        vecs[10] = '{0, 0, 0, 0};
        vecs[11] = '{32767, -1, 32768, 0};

        // reset with random inputs
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            rst = 1;
            drive(1, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
            @(negedge clk);
            chk("rst_mode", int'(mode), 0);
            chk("rst_energy", int'(energy), 0);
            chk("rst_ev", int'(energy_valid), 0);
        end
        rst = 0;
        drive(0, 0, 0);
        mdl_en = 1;

        // one dense window per table entry
        for (int v = 0; v < 12; v++) begin
            samples(64, vecs[v].i, vecs[v].q);
            chk($sformatf("v%0d_ev", v), int'(energy_valid), 1);
            chk($sformatf("v%0d_energy", v), int'(energy), vecs[v].exp_energy);
            @(negedge clk);
            chk($sformatf("v%0d_mode", v), int'(mode), vecs[v].exp_mode);
            chk($sformatf("v%0d_ev_pulse", v), int'(energy_valid), 0);
        end

        // sparse valid: one sample every third cycle
        first_ev = -1;
        for (int c = 0; c < 300 && first_ev < 0; c++) begin
            if (energy_valid) first_ev = c;
            else if (c % 3 == 0 && c < 190) drive(1, 1000, -500);
            else drive(0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0);
        chk("sparse_cycle", first_ev, 190);
        chk("sparse_energy", int'(energy), 1500);
        @(negedge clk);
        chk("sparse_mode", int'(mode), 1);

        // reset in the middle of a window while on
        samples(30, 1000, -500);
        rst = 1;
        drive(1, 1000, -500);
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_energy", int'(energy), 0);
        samples(63, 1000, -500);
        chk("mid_rst_no_ev", int'(energy_valid), 0);
        samples(1, 1000, -500);
        chk("mid_rst_ev", int'(energy_valid), 1);
        chk("mid_rst_energy2", int'(energy), 1500);

        // randomized windows, model-checked every cycle
        for (int w = 0; w < 40; w++) begin
            int lvl;
            lvl = ($urandom_range(0, 7) == 0) ? 32767 : int'($urandom_range(0, 2500));
            if ($urandom_range(0, 3) == 0) begin
                thr_on  = 17'($urandom_range(600, 2000));
                thr_off = 17'($urandom_range(200, int'(thr_on)));
            end
            for (int c = 0; c < 80; c++) begin
                int a, b;
                a = int'($urandom_range(0, lvl));
                b = int'($urandom_range(0, lvl));
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
                if (lvl == 32767 && $urandom_range(0, 5) == 0) a = -32768;
                rst = ($urandom_range(0, 999) == 0);
                drive($urandom_range(0, 3) != 0, a, b);
                @(negedge clk);
            end
        end
        rst = 0;
        drive(0, 0, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
